// File: rtl/lut3d_pkg.sv
// Shared types and elaboration-time helpers for the 3D-LUT config streamer.
package lut3d_pkg;

    typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} lut3d_cfg_state_t;

    localparam int LUT3D_CD_DEF = 8;

    // {B,G,R} beat at the default component width; R occupies the low bits.
    typedef struct packed {
        logic [LUT3D_CD_DEF-1:0] b;
        logic [LUT3D_CD_DEF-1:0] g;
        logic [LUT3D_CD_DEF-1:0] r;
    } lut3d_beat_t;

    function automatic int lut3d_entries(input int gs);
        return gs * gs * gs;
    endfunction

    // Rounded linear ramp from 0 to full scale across the grid nodes.
    function automatic int lut3d_identity_val(input int i, input int gs, input int cd);
        return (i * ((1 << cd) - 1) + (gs - 1) / 2) / (gs - 1);
    endfunction

endpackage

// File: rtl/lut3d_idx_counter.sv
// Nested r/g/b grid counters (r fastest) with a linear entry index.
module lut3d_idx_counter
    import lut3d_pkg::*;
#(
    parameter int  GS     = 33,
    localparam int IW     = $clog2(GS),
    localparam int ADDR_W = $clog2(lut3d_entries(GS))
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [IW-1:0]     r_o,
    output logic [IW-1:0]     g_o,
    output logic [IW-1:0]     b_o,
    output logic [ADDR_W-1:0] n_o,
    output logic              first_o,
    output logic              last_o
);

    localparam logic [IW-1:0]     TOP    = IW'(GS - 1);
    localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(lut3d_entries(GS) - 1);

    logic [IW-1:0]     r_q, g_q, b_q, r_d, g_d, b_d;
    logic [ADDR_W-1:0] n_q, n_d;

    // Clear wins over enable so the final index never steps past N_LAST.
    always_comb begin
        r_d = r_q;
        g_d = g_q;
        b_d = b_q;
        n_d = n_q;
        if (clr_i) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
            n_d = '0;
        end else if (en_i) begin
            n_d = n_q + 1'b1;
            r_d = (r_q == TOP) ? '0 : r_q + 1'b1;
            if (r_q == TOP) begin
                g_d = (g_q == TOP) ? '0 : g_q + 1'b1;
                if (g_q == TOP)
                    b_d = (b_q == TOP) ? '0 : b_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
            n_q <= '0;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
            n_q <= n_d;
        end
    end

    assign r_o     = r_q;
    assign g_o     = g_q;
    assign b_o     = b_q;
    assign n_o     = n_q;
    assign first_o = (n_q == '0);
    assign last_o  = (n_q == N_LAST);

endmodule

// File: rtl/lut3d_cfg_streamer.sv
// Streams GS^3 LUT entries (identity or from memory) starting at a frame boundary,
// with the beat timing matched across both sources by a MEM_LAT-deep tag pipe.
module lut3d_cfg_streamer
    import lut3d_pkg::*;
#(
    parameter int  GS      = 33,
    parameter int  LUT_CD  = 8,
    parameter int  MEM_LAT = 2,
    localparam int ADDR_W  = $clog2(GS * GS * GS)
) (
    input  logic                  p_clk,
    input  logic                  p_rst,
    input  logic                  i_vs,
    input  logic                  i_load_req,
    input  logic                  i_identity,
    output logic                  o_mem_rd,
    output logic [ADDR_W-1:0]     o_mem_addr,
    input  logic [3*LUT_CD-1:0]   i_mem_rdata,
    output logic [3*LUT_CD-1:0]   o_cfg_data,
    output logic                  o_cfg_valid,
    output logic                  o_cfg_last,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int IW = $clog2(GS);

    typedef struct packed {
        logic [LUT_CD-1:0] b;
        logic [LUT_CD-1:0] g;
        logic [LUT_CD-1:0] r;
    } beat_t;

    typedef struct packed {
        logic          valid;
        logic          last;
        logic [IW-1:0] r;
        logic [IW-1:0] g;
        logic [IW-1:0] b;
    } tag_t;

    lut3d_cfg_state_t  state_q;
    logic              mode_q, vs_d_q;
    logic [2:0]        drn_q;
    logic [IW-1:0]     r_idx, g_idx, b_idx;
    logic [ADDR_W-1:0] n_idx;
    logic              idx_first, idx_last, run;

    assign run = (state_q == RUN);

    lut3d_idx_counter #(.GS(GS)) u_idx (
        .clk_i   (p_clk),
        .rst_i   (p_rst),
        .clr_i   (run && idx_last),
        .en_i    (run),
        .r_o     (r_idx),
        .g_o     (g_idx),
        .b_o     (b_idx),
        .n_o     (n_idx),
        .first_o (idx_first),
        .last_o  (idx_last)
    );

    // vs_d resets high so a level-high i_vs out of reset is not taken as an edge.
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            vs_d_q  <= 1'b1;
            drn_q   <= '0;
        end else begin
            vs_d_q <= i_vs;
            case (state_q)
                IDLE: if (i_load_req) begin
                    state_q <= ARM;
                    mode_q  <= i_identity;
                end
                ARM: if (i_vs && !vs_d_q && idx_first) state_q <= RUN;
                RUN: if (idx_last) begin
                    state_q <= DRAIN;
                    drn_q   <= '0;
                end
                DRAIN: if (drn_q == 3'(MEM_LAT)) state_q <= DONE;
                       else drn_q <= drn_q + 1'b1;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_mem_rd   = run && !mode_q;
    assign o_mem_addr = n_idx;

    tag_t tag_in, tag_tail;
    assign tag_in = '{valid: run, last: idx_last, r: r_idx, g: g_idx, b: b_idx};

    generate
        if (MEM_LAT == 0) begin : g_nodly
            assign tag_tail = tag_in;
        end else begin : g_dly
            tag_t pipe_q [MEM_LAT];
            always_ff @(posedge p_clk) begin
                if (p_rst) begin
                    for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= tag_in;
                    for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign tag_tail = pipe_q[MEM_LAT-1];
        end
    endgenerate

    logic [LUT_CD-1:0] id_tbl [GS];
    generate
        for (genvar i = 0; i < GS; i++) begin : g_id
            assign id_tbl[i] = LUT_CD'(lut3d_identity_val(i, GS, LUT_CD));
        end
    endgenerate

    beat_t id_beat;
    assign id_beat = '{b: id_tbl[tag_tail.b], g: id_tbl[tag_tail.g], r: id_tbl[tag_tail.r]};

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            o_cfg_data  <= '0;
            o_cfg_valid <= 1'b0;
            o_cfg_last  <= 1'b0;
        end else begin
            o_cfg_valid <= tag_tail.valid;
            o_cfg_last  <= tag_tail.valid && tag_tail.last;
            if (!tag_tail.valid)
                o_cfg_data <= '0;
            else if (mode_q)
                o_cfg_data <= id_beat;
            else
                o_cfg_data <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_lut3d_cfg_streamer.sv
// Scoreboard bench: a GS=3 streamer for directed loads, plus GS=17 streamers at MEM_LAT 0 and 4.
module tb_lut3d_cfg_streamer;

    localparam int NA = 27;
    localparam int NS = 4913;
    localparam int LA = 2;
    localparam int LC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endfunction

    // GS=3, LUT_CD=8, MEM_LAT=2
    logic        vs_a = 1'b0, req_a = 1'b0, id_a = 1'b0;
    logic        rd_a, val_a, last_a, busy_a, done_a;
    logic [4:0]  addr_a;
    logic [4:0]  dl_a [LA];
    logic [23:0] rdata_a, data_a;

    always @(posedge clk) begin
        dl_a[0] <= addr_a;
        dl_a[1] <= dl_a[0];
    end
    assign rdata_a = {19'd0, dl_a[LA-1]};

    lut3d_cfg_streamer #(.GS(3), .LUT_CD(8), .MEM_LAT(LA)) dut_a (
        .p_clk(clk), .p_rst(rst), .i_vs(vs_a), .i_load_req(req_a), .i_identity(id_a),
        .o_mem_rd(rd_a), .o_mem_addr(addr_a), .i_mem_rdata(rdata_a),
        .o_cfg_data(data_a), .o_cfg_valid(val_a), .o_cfg_last(last_a),
        .o_busy(busy_a), .o_done(done_a));

    // GS=17, LUT_CD=10 at MEM_LAT=0 (b) and MEM_LAT=4 (c), driven together
    logic        vs_s = 1'b0, req_s = 1'b0, id_s = 1'b0;
    logic        rd_b, val_b, last_b, busy_b, done_b;
    logic        rd_c, val_c, last_c, busy_c, done_c;
    logic [12:0] addr_b, addr_c;
    logic [12:0] dl_c [LC];
    logic [29:0] rdata_b, rdata_c, data_b, data_c;

    assign rdata_b = {17'd0, addr_b};
    always @(posedge clk) begin
        dl_c[0] <= addr_c;
        for (int i = 1; i < LC; i++) dl_c[i] <= dl_c[i-1];
    end
    assign rdata_c = {17'd0, dl_c[LC-1]};

    lut3d_cfg_streamer #(.GS(17), .LUT_CD(10), .MEM_LAT(0)) dut_b (
        .p_clk(clk), .p_rst(rst), .i_vs(vs_s), .i_load_req(req_s), .i_identity(id_s),
        .o_mem_rd(rd_b), .o_mem_addr(addr_b), .i_mem_rdata(rdata_b),
        .o_cfg_data(data_b), .o_cfg_valid(val_b), .o_cfg_last(last_b),
        .o_busy(busy_b), .o_done(done_b));

    lut3d_cfg_streamer #(.GS(17), .LUT_CD(10), .MEM_LAT(LC)) dut_c (
        .p_clk(clk), .p_rst(rst), .i_vs(vs_s), .i_load_req(req_s), .i_identity(id_s),
        .o_mem_rd(rd_c), .o_mem_addr(addr_c), .i_mem_rdata(rdata_c),
        .o_cfg_data(data_c), .o_cfg_valid(val_c), .o_cfg_last(last_c),
        .o_busy(busy_c), .o_done(done_c));

    // Expected beats as {last, data}
    logic [24:0] qa [$];
    logic [30:0] qb [$];
    logic [30:0] qc [$];

    function automatic logic [24:0] exp_a(input bit ident, input int n);
        logic [7:0] t [3];
        t = '{8'h00, 8'h80, 8'hFF};
        if (ident) return {n == NA - 1, t[n / 9], t[(n / 3) % 3], t[n % 3]};
        return {n == NA - 1, 19'd0, 5'(n)};
    endfunction

    function automatic logic [9:0] v17(input int i);
        return 10'((i * 1023 + 8) / 16);
    endfunction

    function automatic logic [30:0] exp_s(input bit ident, input int n);
        if (ident) return {n == NS - 1, v17(n / 289), v17((n / 17) % 17), v17(n % 17)};
        return {n == NS - 1, 17'd0, 13'(n)};
    endfunction

    always @(negedge clk) begin
        if (val_a) begin
            if (qa.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL a_beat: got unexpected beat 0x%0h, expected none", data_a);
            end else check("a_beat", {last_a, data_a}, qa.pop_front());
        end
        if (val_b) begin
            if (qb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL b_beat: got unexpected beat 0x%0h, expected none", data_b);
            end else check("b_beat", {last_b, data_b}, qb.pop_front());
        end
        if (val_c) begin
            if (qc.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL c_beat: got unexpected beat 0x%0h, expected none", data_c);
            end else check("c_beat", {last_c, data_c}, qc.pop_front());
        end
    end

    task automatic run_a(input string nm, input bit ident, input bit stall, input int poke, input int rst_at);
        int first, lastv, beats, nlast, lastc, ndone, donec, rds, abad, vseen, bdone;
        bit poked, stop;
        first = -1; lastv = -1; beats = 0; nlast = 0; lastc = -1; ndone = 0; donec = -1;
        rds = 0; abad = 0; vseen = 0; bdone = 0; poked = 0; stop = 0;
        for (int n = 0; n < ((rst_at > 0) ? rst_at : NA); n++) qa.push_back(exp_a(ident, n));
        vs_a = 1'b0;
        @(posedge clk); #1;
        req_a = 1'b1; id_a = ident;
        if (stall) vs_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        check({nm, "_busy_armed"}, busy_a, 1);
        if (stall) begin
            repeat (100) begin @(posedge clk); #1; vseen += int'(val_a); end
            check({nm, "_stall_busy"}, busy_a, 1);
            check({nm, "_stall_beats"}, vseen, 0);
            vs_a = 1'b0;
            @(posedge clk); #1;
        end
        vs_a = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && !stop; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (rst) begin
                check({nm, "_rst_outputs"}, {val_a, last_a, busy_a, done_a, rd_a, data_a, addr_a}, 0);
                rst = 1'b0;
                stop = 1'b1;
            end else begin
                if (rd_a) begin
                    if (addr_a != 5'(rds)) abad++;
                    rds++;
                end
                if (val_a) begin
                    if (first < 0) first = cyc;
                    lastv = cyc;
                    beats++;
                end
                if (last_a) begin nlast++; lastc = cyc; end
                if (done_a) begin ndone++; donec = cyc; bdone = int'(busy_a); end
                req_a = 1'b0;
                if (poke > 0 && beats == poke && !poked) begin
                    req_a = 1'b1; id_a = !ident; poked = 1'b1;
                end
                if (rst_at > 0 && beats == rst_at) rst = 1'b1;
            end
        end
        req_a = 1'b0;
        if (rst_at > 0) begin
            check({nm, "_no_last"}, nlast, 0);
            check({nm, "_beats"}, beats, rst_at);
            check({nm, "_queue"}, qa.size(), 0);
        end else begin
            check({nm, "_first_lat"}, first, LA + 1);
            check({nm, "_beats"}, beats, NA);
            check({nm, "_contig"}, lastv - first + 1, NA);
            check({nm, "_last_pos"}, lastc, first + NA - 1);
            check({nm, "_nlast"}, nlast, 1);
            check({nm, "_ndone"}, ndone, 1);
            check({nm, "_done_pos"}, donec, lastc + 1);
            check({nm, "_busy_at_done"}, bdone, 1);
            check({nm, "_rd_count"}, rds, ident ? 0 : NA);
            check({nm, "_addr_seq"}, abad, 0);
            check({nm, "_idle_after"}, busy_a, 0);
            check({nm, "_queue"}, qa.size(), 0);
        end
    endtask

    task automatic run_s(input string nm, input bit ident);
        int fb, fc, bb, bc, lb, lc, db, dc, rb, rc;
        logic [29:0] b8, fin_b, fin_c;
        fb = -1; fc = -1; bb = 0; bc = 0; lb = -1; lc = -1; db = -1; dc = -1; rb = 0; rc = 0;
        b8 = '0; fin_b = '0; fin_c = '0;
        for (int n = 0; n < NS; n++) begin
            qb.push_back(exp_s(ident, n));
            qc.push_back(exp_s(ident, n));
        end
        vs_s = 1'b0;
        @(posedge clk); #1;
        req_s = 1'b1; id_s = ident;
        @(posedge clk); #1;
        req_s = 1'b0; vs_s = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < NS + 20; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            rb += int'(rd_b);
            rc += int'(rd_c);
            if (val_b) begin
                if (fb < 0) fb = cyc;
                if (bb == 8) b8 = data_b;
                bb++;
            end
            if (val_c) begin
                if (fc < 0) fc = cyc;
                bc++;
            end
            if (last_b) begin lb = cyc; fin_b = data_b; end
            if (last_c) begin lc = cyc; fin_c = data_c; end
            if (done_b) db = cyc;
            if (done_c) dc = cyc;
        end
        check({nm, "_b_first_lat"}, fb, 1);
        check({nm, "_c_first_lat"}, fc, LC + 1);
        check({nm, "_b_beats"}, bb, NS);
        check({nm, "_c_beats"}, bc, NS);
        check({nm, "_b_last_pos"}, lb, fb + NS - 1);
        check({nm, "_c_last_pos"}, lc, fc + NS - 1);
        check({nm, "_b_final"}, fin_b, ident ? 30'h3FFF_FFFF : 30'd4912);
        check({nm, "_c_final"}, fin_c, ident ? 30'h3FFF_FFFF : 30'd4912);
        check({nm, "_b_beat8"}, b8, ident ? 30'h200 : 30'd8);
        check({nm, "_b_done_pos"}, db, lb + 1);
        check({nm, "_c_done_pos"}, dc, lc + 1);
        check({nm, "_b_rd_count"}, rb, ident ? 0 : NS);
        check({nm, "_c_rd_count"}, rc, ident ? 0 : NS);
        check({nm, "_idle_after"}, {busy_b, busy_c}, 0);
        check({nm, "_queues"}, qb.size() + qc.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_outputs", {val_a, last_a, busy_a, done_a, rd_a, data_a, addr_a}, 0);
        check("rst_b_outputs", {val_b, last_b, busy_b, done_b, rd_b, data_b, addr_b}, 0);
        check("rst_c_outputs", {val_c, last_c, busy_c, done_c, rd_c, data_c, addr_c}, 0);
        rst = 1'b0;
        run_a("t1_ident", 1'b1, 1'b0, 0, 0);
        run_a("t2_mem", 1'b0, 1'b0, 0, 0);
        run_a("t3_stall", 1'b1, 1'b1, 0, 0);
        run_a("t4_ignore", 1'b1, 1'b0, 5, 0);
        run_a("t5_rst", 1'b1, 1'b0, 0, 10);
        run_a("t5_reload", 1'b1, 1'b0, 0, 0);
        run_s("t6_ident", 1'b1);
        run_s("t6_mem", 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
